// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks an index range through a spare RF read port
// and streams each word over valid/ready while accumulating a sum checksum.
module rf_dump_reader #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          start,
    input  logic [AW-1:0] first_idx,
    input  logic [AW-1:0] last_idx,
    input  logic          abort,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    logic [AW-1:0] ptr;
    logic [AW-1:0] last_q;
    logic          fetch_done;
    logic          handshake_c;
    logic          load_c;

    assign rf_raddr    = ptr;
    assign handshake_c = out_valid && out_ready;
    assign load_c      = busy && !fetch_done && (!out_valid || out_ready);

    // fetch_done stops the pointer from wrapping past index 31 into extra fetches
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ptr        <= '0;
            last_q     <= '0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            checksum   <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    ptr      <= first_idx;
                    last_q   <= last_idx;
                    checksum <= '0;
                    if (first_idx <= last_idx) begin
                        busy       <= 1'b1;
                        fetch_done <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (abort) begin
                out_valid  <= 1'b0;
                busy       <= 1'b0;
                fetch_done <= 1'b1;
            end else begin
                if (handshake_c) begin
                    checksum <= checksum + out_data;
                    if (out_last) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (!load_c) begin
                        out_valid <= 1'b0;
                    end
                end
                // A load in the same cycle as a handshake refills the output stage
                if (load_c) begin
                    out_data  <= rf_rdata;
                    out_idx   <= ptr;
                    out_last  <= (ptr == last_q);
                    out_valid <= 1'b1;
                    if (ptr == last_q) begin
                        fetch_done <= 1'b1;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with a combinational register-file model.
module tb_rf_dump_reader;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          cpu_clk;
    logic          cpu_rst;
    logic          start;
    logic [AW-1:0] first_idx;
    logic [AW-1:0] last_idx;
    logic          abort;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] rf_mem [32];
    int checks;
    int errors;

    assign rf_rdata = rf_mem[rf_raddr];

    rf_dump_reader #(.AW(AW), .DW(DW)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .start    (start),
        .first_idx(first_idx),
        .last_idx (last_idx),
        .abort    (abort),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic begin_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        cpu_rst = 1'b1;
        #3;
        checks++;
        if ({out_valid, busy, done, out_last} !== 4'b0 || out_data !== '0 || out_idx !== '0
            || checksum !== '0 || rf_raddr !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b last=%b data=%h idx=%0d chk=%h raddr=%0d required all zero",
                     out_valid, busy, done, out_last, out_data, out_idx, checksum, rf_raddr);
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic test_full_dump;
        logic exp_last;
        out_ready = 1'b1;
        begin_dump(5'd0, 5'd31);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: valid=%b busy=%b required valid=0 busy=1", out_valid, busy);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge cpu_clk);
            exp_last = (i == 31);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== AW'(i) || out_data !== rf_mem[i] || out_last !== exp_last) begin
                errors++;
                $display("FAIL full_beat%0d: valid=%b idx=%0d data=%h last=%b required valid=1 idx=%0d data=%h last=%b",
                         i, out_valid, out_idx, out_data, out_last, i, rf_mem[i], exp_last);
            end
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || checksum !== 32'hF1F1F1F0) begin
            errors++;
            $display("FAIL full_end: done=%b valid=%b busy=%b chk=%h required done=1 valid=0 busy=0 chk=f1f1f1f0",
                     done, out_valid, busy, checksum);
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_after: done=%b valid=%b required done=0 valid=0", done, out_valid);
        end
    endtask

    task automatic test_backpressure;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int nacc;
        int k;
        bit seen_done;
        logic pv, pr;
        logic [DW-1:0] pdata;
        logic [AW-1:0] pidx;
        nacc = 0; k = 0; seen_done = 0; pv = 0; pr = 0; pdata = '0; pidx = '0;
        out_ready = pat[0];
        begin_dump(5'd3, 5'd6);
        for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pdata || out_idx !== pidx) begin
                    errors++;
                    $display("FAIL bp_hold: valid=%b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                             out_valid, out_idx, out_data, pidx, pdata);
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
            end else begin
                out_ready = pat[k % 4];
                k++;
                if (out_valid && out_ready) begin
                    checks++;
                    if (nacc > 3 || out_idx !== AW'(3 + nacc) || out_data !== rf_mem[3 + nacc]) begin
                        errors++;
                        $display("FAIL bp_beat%0d: idx=%0d data=%h required idx=%0d", nacc, out_idx, out_data, 3 + nacc);
                    end
                    nacc++;
                end
                pv = out_valid; pr = out_ready; pdata = out_data; pidx = out_idx;
                @(negedge cpu_clk);
            end
        end
        checks++;
        if (!seen_done || nacc != 4 || checksum !== 32'h12121212 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: done_seen=%0d beats=%0d chk=%h busy=%b required done_seen=1 beats=4 chk=12121212 busy=0",
                     seen_done, nacc, checksum, busy);
        end
        out_ready = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic test_single;
        rf_mem[5] = 32'hDEADBEEF;
        out_ready = 1'b1;
        begin_dump(5'd5, 5'd5);
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd5 || out_last !== 1'b1 || out_data !== 32'hDEADBEEF || done !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: valid=%b idx=%0d last=%b data=%h done=%b required 1 5 1 deadbeef 0",
                     out_valid, out_idx, out_last, out_data, done);
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || checksum !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b busy=%b chk=%h required 1 0 0 deadbeef",
                     done, out_valid, busy, checksum);
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: done=%b required 0", done);
        end
        rf_mem[5] = 32'h05050505;
    endtask

    task automatic test_empty;
        begin_dump(5'd9, 5'd4);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || checksum !== '0) begin
            errors++;
            $display("FAIL empty_done: done=%b busy=%b valid=%b chk=%h required 1 0 0 0", done, busy, out_valid, checksum);
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_after: done=%b busy=%b valid=%b required 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        begin_dump(5'd0, 5'd31);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        first_idx = 5'd9;
        last_idx  = 5'd10;
        start     = 1'b1;
        @(negedge cpu_clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd2 || out_data !== rf_mem[2] || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_ignore_start: valid=%b idx=%0d data=%h busy=%b required 1 2 %h 1",
                     out_valid, out_idx, out_data, busy, rf_mem[2]);
        end
        abort = 1'b1;
        @(negedge cpu_clk);
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || checksum !== 32'h01010101) begin
            errors++;
            $display("FAIL abort_drop: valid=%b busy=%b done=%b chk=%h required 0 0 0 01010101",
                     out_valid, busy, done, checksum);
        end
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || checksum !== 32'h01010101) begin
            errors++;
            $display("FAIL abort_after: valid=%b done=%b chk=%h required 0 0 01010101", out_valid, done, checksum);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        begin_dump(5'd0, 5'd31);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        #2;
        cpu_rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, done, out_last} !== 4'b0 || out_data !== '0 || out_idx !== '0
            || checksum !== '0 || rf_raddr !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b last=%b data=%h idx=%0d chk=%h raddr=%0d required all zero",
                     out_valid, busy, done, out_last, out_data, out_idx, checksum, rf_raddr);
        end
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        begin_dump(5'd7, 5'd7);
        @(negedge cpu_clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7 || out_data !== 32'h07070707 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_beat: valid=%b idx=%0d data=%h last=%b required 1 7 07070707 1",
                     out_valid, out_idx, out_data, out_last);
        end
        @(negedge cpu_clk);
        checks++;
        if (done !== 1'b1 || checksum !== 32'h07070707 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: done=%b chk=%h busy=%b required 1 07070707 0", done, checksum, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h01010101;
        start     = 1'b0;
        abort     = 1'b0;
        first_idx = '0;
        last_idx  = '0;
        out_ready = 1'b1;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_single();
        test_empty();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Debug/trace reader for the CPU register file. On a start request it walks a contiguous index range through one RF read port and streams each 32-bit value out over a valid/ready interface.
- Sits beside the RF on the miniRV SoC debug path and uses a spare read port: it drives the read address and samples the combinational read data.
- Produces a running 32-bit sum checksum of the transferred words.

Parameters:
- AW, 5, register index width (32 registers)
- DW, 32, register data width

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- start  in  1  begin dump; sampled only when busy=0
- first_idx  in  AW  first register index, latched on start
- last_idx  in  AW  last register index inclusive, latched on start
- abort  in  1  synchronous cancel of an active dump
- rf_raddr  out  AW  RF read address; combinational RF response expected same cycle
- rf_rdata  in  DW  RF read data for rf_raddr
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  consumer accepts the beat when out_valid&&out_ready at an edge
- out_data  out  DW  register value
- out_idx  out  AW  index of out_data
- out_last  out  1  beat is the final one (out_idx==last latched)
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse on dump completion
- checksum  out  DW  sum mod 2^DW of the words sent; valid from done, held until next start

Behaviour:
- Reset (async): busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, checksum=0, rf_raddr=0. Internal ptr=0, last=0, fetch_done=0.
- rf_raddr = ptr (registered fetch pointer) at all times.
- IDLE (busy=0): a start at an edge latches first/last, sets ptr=first, and clears checksum to 0.
  - If first_idx<=last_idx: busy=1 and fetch_done=0.
  - If first_idx>last_idx: empty dump. busy stays 0, no beats, done=1 in the following cycle, checksum=0.
- Load condition (busy && !fetch_done && (!out_valid || out_ready)), at each edge:
  - out_data<=rf_rdata, out_idx<=ptr, out_last<=(ptr==last), out_valid<=1.
  - If ptr==last, fetch_done<=1; otherwise ptr<=ptr+1.
- The fetch_done flag prevents the 5-bit ptr wrap at 31 from causing extra fetches.
- Latency: start at edge E0 gives the first beat valid after E1. Throughput is 1 beat/cycle with out_ready held high.
- Backpressure: while out_valid && !out_ready, out_data/out_idx/out_last and ptr hold.
- Handshake edge: checksum<=checksum+out_data, wrapping mod 2^32.
  - If out_last, then at that edge out_valid<=0, busy<=0, and done is high for the next cycle only.
  - If not out_last and no load, out_valid<=0.
- start while busy=1 is ignored.
- abort while busy at an edge: out_valid<=0, busy<=0, fetch_done<=1, no done pulse, checksum holds partial sum. abort while idle has no effect. abort has priority over a simultaneous handshake or load.
- Reset mid-dump returns every output to its reset value immediately.
- Index 0 is dumped like any other; the RF returns 0 for it.
- No coherence with concurrent RF writes: each beat carries whatever rf_rdata held at its load edge.

Test Plan:
- Full dump first=0, last=31, out_ready=1, RF[i]=i*0x01010101 -> 32 beats on consecutive cycles, idx 0..31, out_last only on idx 31, then one done pulse, checksum=0x0000_01F0×0x01010101 mod 2^32 = 0xF1F1F1F0 -> beat 31 is never followed by a wrapped beat 0.
- Backpressure first=3, last=6, out_ready toggling 1,0,0,1,... -> each beat holds stable while stalled, order 3,4,5,6, with no duplicates or drops. checksum equals the sum of RF[3..6].
- Single register first=last=5, RF[5]=0xDEADBEEF -> one beat with out_last=1, done pulses one cycle after the handshake, checksum=0xDEADBEEF.
- Empty range first=9, last=4 -> out_valid never asserts, done pulses one cycle after start, checksum=0, busy stays 0.
- abort asserted on the edge of the 3rd handshake of a 0..31 dump, with start pulsed again mid-dump -> out_valid and busy drop and no done pulse. checksum holds the sum of the first 2 words. The mid-dump start has no effect.
- Async cpu_rst pulsed between edges during a dump -> all outputs 0 immediately. A subsequent start works normally from a clean state.
